uart_tx_serializer: RTL and testbench
=====================================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of TX FIFO entries (power of two, min 2).
REQ-002 SHALL have ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- tx_fifo_wr_en  in  1  push strobe from register file
- tx_fifo_data  in  8  byte to push
- uart_en  in  1  global enable
- tx_en  in  1  transmitter enable
- parity_enable  in  1  parity bit present
- parity  in  1  0 = even, 1 = odd
- stop_bit  in  1  0 = one stop bit, 1 = two stop bits
- baud_rate  in  16  clock cycles per bit
- tx_serial  out  1  serial line, idle high, registered
- tx_fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- busy  out  1  frame in progress or FIFO non-empty

Function
REQ-003 SHALL push tx_fifo_data on any rising edge where tx_fifo_wr_en=1 and tx_fifo_full=0.
REQ-004 SHALL silently drop the write when tx_fifo_full=1, even if a pop occurs in the same cycle.
REQ-005 SHALL derive full and empty from an occupancy count of 0..FIFO_DEPTH, with read/write pointers wrapping modulo FIFO_DEPTH.
REQ-006 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-007 In IDLE, when FIFO non-empty and uart_en=1 and tx_en=1, SHALL pop the head into the shift register, latch parity_enable, parity and stop_bit for the frame, and enter START.
REQ-008 SHALL define bit period P = baud_rate cycles, with baud_rate 0 treated as 1.
REQ-009 SHALL hold each state's line level for exactly P cycles using a 16-bit down-counter reloaded on each bit boundary.
REQ-010 START SHALL drive 0 for P cycles, then enter DATA.
REQ-011 DATA SHALL shift out 8 bits LSB first, P cycles each, using a 3-bit bit index.
REQ-012 After bit 7, DATA SHALL enter PARITY if the latched parity_enable=1, else STOP.
REQ-013 PARITY SHALL drive XOR of the data bits when parity=0 (even), or its inverse when parity=1 (odd), for P cycles.
REQ-014 STOP SHALL drive 1 for P cycles (stop_bit=0) or 2P cycles (stop_bit=1), then return to IDLE.
REQ-015 When leaving STOP with the FIFO non-empty and enables high, SHALL pass through IDLE for exactly one cycle; that cycle pops, giving a one-cycle idle gap between frames.
REQ-016 tx_serial SHALL be 1 in IDLE.
REQ-017 tx_serial SHALL be a flop updated on the same edge as the state change, so line level tracks state with no extra delay.
REQ-018 Latency: data written at edge N SHALL be popped at edge N+1, with tx_serial=0 (start bit) visible after edge N+1.
REQ-019 tx_en=0 mid-frame SHALL let the current frame complete and prevent new pops.
REQ-020 uart_en=0 SHALL, on the next edge, abort any frame, return to IDLE, drive tx_serial=1 and flush the FIFO (count=0, pointers=0).
REQ-021 Writes SHALL be ignored while uart_en=0.
REQ-022 Changes to baud_rate, parity or stop_bit mid-frame SHALL NOT affect the frame in flight; baud_rate SHALL be latched at pop.
REQ-023 busy SHALL equal (state != IDLE) OR (FIFO non-empty), combinationally.
REQ-024 tx_fifo_full SHALL be combinational from the count.

Reset
REQ-025 On reset=1 at a rising edge, SHALL set state=IDLE, tx_serial=1, count=0, pointers=0, bit counter=0 and baud counter=0.
REQ-026 Reset outputs SHALL be tx_fifo_full=0 and busy=0.
REQ-027 Reset mid-frame SHALL abandon the frame with no partial bits afterward.
REQ-028 FIFO storage contents need not be reset.

Verification
REQ-029 baud_rate=4, uart_en=tx_en=1, parity_enable=0, stop_bit=0, write 0xA5 -> tx_serial over 40 cycles: 0 then 1,0,1,0,0,1,0,1, then 1; 4 cycles per bit; busy=0 after.
REQ-030 baud_rate=2, parity_enable=1, parity=0, write 0x07 -> parity bit 1; repeat with parity=1 -> parity bit 0; stop_bit=1 -> stop high for 4 cycles.
REQ-031 tx_en=0, write 9 bytes 0x00..0x08 with FIFO_DEPTH=8 -> tx_fifo_full=1 after 8th write, 0x08 dropped; set tx_en=1 -> exactly 0x00..0x07 sent in order, 1-cycle idle gaps.
REQ-032 Mid-DATA of byte 0x3C, drop uart_en for 1 cycle with 2 bytes queued -> tx_serial=1 next cycle, busy=0, count=0, no further frames.
REQ-033 Assert reset during the PARITY state -> next cycle tx_serial=1, busy=0, tx_fifo_full=0; a fresh write then transmits correctly.
REQ-034 baud_rate=0, write 0x81 -> 1-cycle bits: 0,1,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Byte FIFO feeding an 8N1/8E1/8O1/8x2 UART transmitter. Bytes pushed from
//   the register file are queued and serialized LSB first with a start bit,
//   an optional parity bit and one or two stop bits. Per-frame settings
//   (baud_rate, parity_enable, parity, stop_bit) are captured when a byte is
//   popped, so register changes never disturb a frame already on the line.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   tx_fifo_wr_en  in   push strobe (ignored when full or uart_en=0)
//   tx_fifo_data   in   byte to push
//   uart_en        in   global enable; low aborts the frame and flushes the FIFO
//   tx_en          in   transmitter enable; low stops new frames from starting
//   parity_enable  in   parity bit present
//   parity         in   0 = even, 1 = odd
//   stop_bit       in   0 = one stop bit, 1 = two stop bits
//   baud_rate      in   clock cycles per bit (0 behaves as 1)
//   tx_serial      out  serial line, idle high, registered
//   tx_fifo_full   out  FIFO holds FIFO_DEPTH entries
//   busy           out  frame in progress or FIFO non-empty

module uart_tx_serializer #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tx_fifo_wr_en,
  input  logic [7:0]  tx_fifo_data,
  input  logic        uart_en,
  input  logic        tx_en,
  input  logic        parity_enable,
  input  logic        parity,
  input  logic        stop_bit,
  input  logic [15:0] baud_rate,
  output logic        tx_serial,
  output logic        tx_fifo_full,
  output logic        busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Transmitter
  state_e        r_state;
  logic          r_tx;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_idx;
  logic [15:0]   r_baud_cnt;
  logic [15:0]   r_period_m1;
  logic          r_par_bit;
  logic          r_pe;
  logic          r_sb;
  logic          r_stop_second;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head;
  logic [15:0]   w_period_m1;
  logic          w_bit_done;

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  // Full blocks the push even when a pop frees a slot on the same edge.
  assign w_push      = uart_en & tx_fifo_wr_en & ~w_full;
  assign w_pop       = (r_state == StIdle) & ~w_empty & uart_en & tx_en;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_period_m1 = (baud_rate == 16'd0) ? 16'd0 : (baud_rate - 16'd1);
  assign w_bit_done  = (r_baud_cnt == 16'd0);

  assign tx_serial    = r_tx;
  assign tx_fifo_full = w_full;
  assign busy         = (r_state != StIdle) | ~w_empty;

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_fifo_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !uart_en) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Line level is registered alongside the state so it changes on the same edge.
  always_ff @(posedge clock) begin
    if (reset || !uart_en) begin
      r_state       <= StIdle;
      r_tx          <= 1'b1;
      r_bit_idx     <= 3'd0;
      r_baud_cnt    <= 16'd0;
      r_stop_second <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift       <= w_head;
            r_par_bit     <= (^w_head) ^ parity;
            r_pe          <= parity_enable;
            r_sb          <= stop_bit;
            r_period_m1   <= w_period_m1;
            r_baud_cnt    <= w_period_m1;
            r_bit_idx     <= 3'd0;
            r_stop_second <= 1'b0;
            r_tx          <= 1'b0;
            r_state       <= StStart;
          end
        end

        StStart: begin
          if (w_bit_done) begin
            r_baud_cnt <= r_period_m1;
            r_tx       <= r_shift[0];
            r_state    <= StData;
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end

        StData: begin
          if (w_bit_done) begin
            r_baud_cnt <= r_period_m1;
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= 3'd0;
              if (r_pe) begin
                r_tx    <= r_par_bit;
                r_state <= StParity;
              end else begin
                r_tx    <= 1'b1;
                r_state <= StStop;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end

        StParity: begin
          if (w_bit_done) begin
            r_baud_cnt <= r_period_m1;
            r_tx       <= 1'b1;
            r_state    <= StStop;
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end

        StStop: begin
          if (w_bit_done) begin
            // Second stop bit reuses the same period instead of a 2P count,
            // so the 16-bit counter never overflows at large baud_rate.
            if (r_sb && !r_stop_second) begin
              r_stop_second <= 1'b1;
              r_baud_cnt    <= r_period_m1;
            end else begin
              r_stop_second <= 1'b0;
              r_tx          <= 1'b1;
              r_state       <= StIdle;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  logic        clock;
  logic        reset;
  logic        tx_fifo_wr_en;
  logic [7:0]  tx_fifo_data;
  logic        uart_en;
  logic        tx_en;
  logic        parity_enable;
  logic        parity;
  logic        stop_bit;
  logic [15:0] baud_rate;
  logic        tx_serial;
  logic        tx_fifo_full;
  logic        busy;

  int n_vec;
  int n_err;

  // Expected line levels, one entry per clock cycle.
  logic exp_q[$];

  uart_tx_serializer #(
    .FIFO_DEPTH(8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .tx_fifo_wr_en (tx_fifo_wr_en),
    .tx_fifo_data  (tx_fifo_data),
    .uart_en       (uart_en),
    .tx_en         (tx_en),
    .parity_enable (parity_enable),
    .parity        (parity),
    .stop_bit      (stop_bit),
    .baud_rate     (baud_rate),
    .tx_serial     (tx_serial),
    .tx_fifo_full  (tx_fifo_full),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: a frame is a list of bit levels, each held for P cycles.
  task automatic model_frame(input logic [7:0] d, input int unsigned br, input bit pe,
                             input bit par, input bit sb);
    int unsigned p;
    logic        bits[$];
    p = (br == 0) ? 1 : br;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ par);
    bits.push_back(1'b1);
    if (sb) bits.push_back(1'b1);
    foreach (bits[i]) repeat (p) exp_q.push_back(bits[i]);
  endtask

  task automatic set_cfg(input int unsigned br, input bit pe, input bit par, input bit sb);
    baud_rate     = 16'(br);
    parity_enable = pe;
    parity        = par;
    stop_bit      = sb;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_vec++;
    if (tx_serial !== 1'b1) begin
      n_err++; $display("FAIL reset_tx: got %b want 1", tx_serial);
    end
    n_vec++;
    if (tx_fifo_full !== 1'b0) begin
      n_err++; $display("FAIL reset_full: got %b want 0", tx_fifo_full);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    set_cfg(4, 0, 0, 0);
    exp_q.delete();
    model_frame(8'hA5, 4, 0, 0, 0);
    tx_fifo_wr_en = 1'b1; tx_fifo_data = 8'hA5;
    tick();
    tx_fifo_wr_en = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      tick();
      n_vec++;
      if (tx_serial !== exp_q[k]) begin
        n_err++; $display("FAIL basic_a5 cyc %0d: got %b want %b", k, tx_serial, exp_q[k]);
      end
    end
    tick();
    n_vec++;
    if (busy !== 1'b0 || tx_serial !== 1'b1) begin
      n_err++; $display("FAIL basic_idle: busy=%b tx=%b want busy=0 tx=1", busy, tx_serial);
    end
  endtask

  task automatic test_parity();
    bit   cfg_par[3];
    bit   cfg_sb[3];
    logic want_pb[3];
    cfg_par = '{1'b0, 1'b1, 1'b0};
    cfg_sb  = '{1'b0, 1'b0, 1'b1};
    want_pb = '{1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      int ones;
      set_cfg(2, 1, cfg_par[t], cfg_sb[t]);
      exp_q.delete();
      model_frame(8'h07, 2, 1, cfg_par[t], cfg_sb[t]);
      tx_fifo_wr_en = 1'b1; tx_fifo_data = 8'h07;
      tick();
      tx_fifo_wr_en = 1'b0;
      ones = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
        tick();
        n_vec++;
        if (tx_serial !== exp_q[k]) begin
          n_err++; $display("FAIL parity_%0d cyc %0d: got %b want %b", t, k, tx_serial, exp_q[k]);
        end
        // Parity bit occupies cycles 18..19 (start 2 + data 16).
        if (k == 18) begin
          n_vec++;
          if (tx_serial !== want_pb[t]) begin
            n_err++; $display("FAIL parity_bit_%0d: got %b want %b", t, tx_serial, want_pb[t]);
          end
        end
        if (k >= 20 && tx_serial === 1'b1) ones++;
      end
      n_vec++;
      if (ones != (cfg_sb[t] ? 4 : 2)) begin
        n_err++; $display("FAIL stop_len_%0d: got %0d want %0d", t, ones, cfg_sb[t] ? 4 : 2);
      end
      tick();
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++; $display("FAIL parity_idle_%0d: busy got %b want 0", t, busy);
      end
    end
  endtask

  task automatic test_full();
    set_cfg(2, 0, 0, 0);
    tx_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tx_fifo_wr_en = 1'b1; tx_fifo_data = 8'(i);
      tick();
      if (i == 6) begin
        n_vec++;
        if (tx_fifo_full !== 1'b0) begin
          n_err++; $display("FAIL full_early: got %b want 0", tx_fifo_full);
        end
      end
      if (i >= 7) begin
        n_vec++;
        if (tx_fifo_full !== 1'b1) begin
          n_err++; $display("FAIL full_after_%0d: got %b want 1", i + 1, tx_fifo_full);
        end
      end
    end
    tx_fifo_wr_en = 1'b0;
    tick();
    n_vec++;
    if (busy !== 1'b1 || tx_serial !== 1'b1) begin
      n_err++; $display("FAIL full_hold: busy=%b tx=%b want busy=1 tx=1", busy, tx_serial);
    end
    exp_q.delete();
    for (int b = 0; b < 8; b++) begin
      model_frame(8'(b), 2, 0, 0, 0);
      if (b < 7) exp_q.push_back(1'b1);
    end
    tx_en = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      tick();
      n_vec++;
      if (tx_serial !== exp_q[k]) begin
        n_err++; $display("FAIL full_drain cyc %0d: got %b want %b", k, tx_serial, exp_q[k]);
      end
    end
    tick();
    n_vec++;
    if (busy !== 1'b0 || tx_fifo_full !== 1'b0) begin
      n_err++; $display("FAIL full_done: busy=%b full=%b want 0 0", busy, tx_fifo_full);
    end
  endtask

  task automatic test_abort();
    set_cfg(4, 0, 0, 0);
    exp_q.delete();
    model_frame(8'h3C, 4, 0, 0, 0);
    tx_fifo_wr_en = 1'b1; tx_fifo_data = 8'h3C;
    tick();
    for (int k = 0; k < 16; k++) begin
      tx_fifo_wr_en = (k < 2);
      tx_fifo_data  = (k == 0) ? 8'h11 : 8'h22;
      tick();
      n_vec++;
      if (tx_serial !== exp_q[k]) begin
        n_err++; $display("FAIL abort_pre cyc %0d: got %b want %b", k, tx_serial, exp_q[k]);
      end
    end
    // Now mid-DATA; a write presented while disabled must be dropped.
    uart_en = 1'b0;
    tx_fifo_wr_en = 1'b1; tx_fifo_data = 8'h55;
    tick();
    tx_fifo_wr_en = 1'b0;
    n_vec++;
    if (tx_serial !== 1'b1 || busy !== 1'b0 || tx_fifo_full !== 1'b0) begin
      n_err++;
      $display("FAIL abort_now: tx=%b busy=%b full=%b want 1 0 0", tx_serial, busy, tx_fifo_full);
    end
    uart_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_vec++;
      if (tx_serial !== 1'b1 || busy !== 1'b0) begin
        n_err++; $display("FAIL abort_quiet cyc %0d: tx=%b busy=%b want 1 0", k, tx_serial, busy);
      end
    end
  endtask

  task automatic test_reset_parity();
    set_cfg(2, 1, 0, 0);
    exp_q.delete();
    model_frame(8'h5A, 2, 1, 0, 0);
    tx_fifo_wr_en = 1'b1; tx_fifo_data = 8'h5A;
    tick();
    for (int k = 0; k <= 18; k++) begin
      tx_fifo_wr_en = (k < 9);
      tx_fifo_data  = 8'h90 + 8'(k);
      tick();
      n_vec++;
      if (tx_serial !== exp_q[k]) begin
        n_err++; $display("FAIL rstpar_pre cyc %0d: got %b want %b", k, tx_serial, exp_q[k]);
      end
    end
    tx_fifo_wr_en = 1'b0;
    n_vec++;
    if (tx_fifo_full !== 1'b1) begin
      n_err++; $display("FAIL rstpar_full: got %b want 1", tx_fifo_full);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (tx_serial !== 1'b1 || busy !== 1'b0 || tx_fifo_full !== 1'b0) begin
      n_err++;
      $display("FAIL rstpar_after: tx=%b busy=%b full=%b want 1 0 0", tx_serial, busy,
               tx_fifo_full);
    end
    set_cfg(3, 1, 1, 1);
    exp_q.delete();
    model_frame(8'hC3, 3, 1, 1, 1);
    tx_fifo_wr_en = 1'b1; tx_fifo_data = 8'hC3;
    tick();
    tx_fifo_wr_en = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      tick();
      n_vec++;
      if (tx_serial !== exp_q[k]) begin
        n_err++; $display("FAIL rstpar_fresh cyc %0d: got %b want %b", k, tx_serial, exp_q[k]);
      end
    end
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL rstpar_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_baud0();
    logic [9:0] want;
    want = 10'b11_0000_0010;  // bit k is the line level k cycles after the pop
    set_cfg(0, 0, 0, 0);
    tx_fifo_wr_en = 1'b1; tx_fifo_data = 8'h81;
    tick();
    tx_fifo_wr_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_vec++;
      if (tx_serial !== want[k]) begin
        n_err++; $display("FAIL baud0 cyc %0d: got %b want %b", k, tx_serial, want[k]);
      end
    end
    tick();
    n_vec++;
    if (busy !== 1'b0 || tx_serial !== 1'b1) begin
      n_err++; $display("FAIL baud0_idle: busy=%b tx=%b want 0 1", busy, tx_serial);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int unsigned br;
      bit          pe, par, sb;
      int          nb;
      logic [7:0]  bytes[4];
      br  = $urandom_range(0, 5);
      pe  = 1'($urandom);
      par = 1'($urandom);
      sb  = 1'($urandom);
      nb  = $urandom_range(1, 4);
      set_cfg(br, pe, par, sb);
      exp_q.delete();
      for (int i = 0; i < nb; i++) begin
        bytes[i] = 8'($urandom);
        model_frame(bytes[i], br, pe, par, sb);
        if (i < nb - 1) exp_q.push_back(1'b1);
      end
      for (int i = 0; i < nb; i++) begin
        tx_fifo_wr_en = 1'b1; tx_fifo_data = bytes[i];
        tick();
        if (i > 0) begin
          n_vec++;
          if (tx_serial !== exp_q[i-1]) begin
            n_err++;
            $display("FAIL rand_%0d cyc %0d: got %b want %b", it, i - 1, tx_serial, exp_q[i-1]);
          end
        end
      end
      tx_fifo_wr_en = 1'b0;
      for (int k = nb - 1; k < exp_q.size(); k++) begin
        tick();
        n_vec++;
        if (tx_serial !== exp_q[k]) begin
          n_err++; $display("FAIL rand_%0d cyc %0d: got %b want %b", it, k, tx_serial, exp_q[k]);
        end
        // Single-byte frames: settings already captured, so disturb them.
        if (nb == 1) set_cfg($urandom_range(0, 65535), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      tick();
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++; $display("FAIL rand_%0d_idle: busy got %b want 0", it, busy);
      end
    end
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    reset         = 1'b1;
    tx_fifo_wr_en = 1'b0;
    tx_fifo_data  = 8'h00;
    uart_en       = 1'b1;
    tx_en         = 1'b1;
    parity_enable = 1'b0;
    parity        = 1'b0;
    stop_bit      = 1'b0;
    baud_rate     = 16'd4;
    test_reset();
    test_basic();
    test_parity();
    test_full();
    test_abort();
    test_reset_parity();
    test_baud0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
